fm_wm_adj_reader: RTL and testbench

Drain-side reader for the FM·WM·ADJ result memory. After `done_comb`, it walks every node row of that memory and reduces each row to a class index with an argmax. It streams one (node, class) result per row over a valid/ready handshake, then flags `done_read`. It sits between the combination stage's result memory and the top-level prediction output.

---
 rtl/fm_wm_adj_reader.sv | 136 +++++++++++++
 tb/tb_fm_wm_adj_reader.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/fm_wm_adj_reader.sv
// fm_wm_adj_reader: drains the FM*WM*ADJ result memory after done_comb.
// Each node row is reduced to the index of its largest element, and one
// (node, class) pair per row goes out on a valid/ready handshake. done_read
// is raised once the last row has been accepted.
// Build option: define FM_WM_ADJ_SIGNED_ARGMAX_EN to compare elements as
// two's-complement signed values; the default compares them unsigned.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for done_comb; node and read address held at 0
// ISSUE   | read address driven from the current node index
// CAPTURE | memory data valid; argmax latched, class_valid set
// OUT     | result held until the consumer accepts it
// DONE    | done_read high until done_comb drops

module fm_wm_adj_reader #(
    parameter int FEATURE_ROWS   = 6,
    parameter int NUM_OF_NODES   = 6,
    parameter int WEIGHT_COLS    = 3,
    parameter int DOT_PROD_WIDTH = 16,
    parameter int FEATURE_WIDTH  = $clog2(FEATURE_ROWS),
    parameter int NODE_W         = $clog2(NUM_OF_NODES),
    parameter int CLASS_W        = (WEIGHT_COLS > 1) ? $clog2(WEIGHT_COLS) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      done_comb,
    input  logic [DOT_PROD_WIDTH-1:0] fm_wm_adj_out [0:WEIGHT_COLS-1],
    output logic [FEATURE_WIDTH-1:0]  read_row_adj,
    output logic                      class_valid,
    input  logic                      class_ready,
    output logic [NODE_W-1:0]         class_node,
    output logic [CLASS_W-1:0]        class_idx,
    output logic                      done_read
);

    typedef enum logic [2:0] {IDLE, ISSUE, CAPTURE, OUT, DONE} state_t;

    localparam logic [NODE_W-1:0] LAST_NODE = NODE_W'(NUM_OF_NODES - 1);

    state_t                     state, state_nxt;
    logic [NODE_W-1:0]          node, node_nxt;
    logic [FEATURE_WIDTH-1:0]   row_nxt;
    logic                       valid_nxt;
    logic [NODE_W-1:0]          cnode_nxt;
    logic [CLASS_W-1:0]         cidx_nxt;
    logic                       done_nxt;
    logic [DOT_PROD_WIDTH-1:0]  best_val;
    logic [CLASS_W-1:0]         best_idx;

    // Argmax scan from column 0 upward; strict compare keeps the lowest index on ties.
    always_comb begin
        best_val = fm_wm_adj_out[0];
        best_idx = '0;
        for (int c = 1; c < WEIGHT_COLS; c++) begin
`ifdef FM_WM_ADJ_SIGNED_ARGMAX_EN
            if ($signed(fm_wm_adj_out[c]) > $signed(best_val)) begin
`else
            if (fm_wm_adj_out[c] > best_val) begin
`endif
                best_val = fm_wm_adj_out[c];
                best_idx = CLASS_W'(c);
            end
        end
    end

    // State and all outputs are registered; the read address never follows inputs combinationally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            node         <= '0;
            read_row_adj <= '0;
            class_valid  <= 1'b0;
            class_node   <= '0;
            class_idx    <= '0;
            done_read    <= 1'b0;
        end else begin
            state        <= state_nxt;
            node         <= node_nxt;
            read_row_adj <= row_nxt;
            class_valid  <= valid_nxt;
            class_node   <= cnode_nxt;
            class_idx    <= cidx_nxt;
            done_read    <= done_nxt;
        end
    end

    // Next-state and next-output logic; everything holds unless a state changes it.
    always_comb begin
        state_nxt = state;
        node_nxt  = node;
        row_nxt   = read_row_adj;
        valid_nxt = class_valid;
        cnode_nxt = class_node;
        cidx_nxt  = class_idx;
        done_nxt  = done_read;
        unique case (state)
            IDLE: begin
                node_nxt = '0;
                row_nxt  = '0;
                if (done_comb) state_nxt = ISSUE;
            end
            ISSUE: begin
                row_nxt   = FEATURE_WIDTH'(node);
                state_nxt = CAPTURE;
            end
            CAPTURE: begin
                cidx_nxt  = best_idx;
                cnode_nxt = node;
                valid_nxt = 1'b1;
                state_nxt = OUT;
            end
            OUT: begin
                // done_comb is deliberately ignored here so a started sweep always finishes
                if (class_valid && class_ready) begin
                    valid_nxt = 1'b0;
                    if (node == LAST_NODE) begin
                        done_nxt  = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        node_nxt  = node + 1'b1;
                        state_nxt = ISSUE;
                    end
                end
            end
            DONE: begin
                if (!done_comb) begin
                    done_nxt  = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_fm_wm_adj_reader.sv
// Directed bench for fm_wm_adj_reader: reset, basic sweep, backpressure,
// ties/sign handling, done_comb drop and reset in the middle of a sweep.
`timescale 1ns/1ps

module tb_fm_wm_adj_reader;

    logic        clk;
    logic        reset;
    logic        done_comb;
    logic [15:0] rd_data [0:2];
    logic [2:0]  read_row_adj;
    logic        class_valid;
    logic        class_ready;
    logic [2:0]  class_node;
    logic [1:0]  class_idx;
    logic        done_read;

    logic [15:0] mem [0:5][0:2];
    int          exp_cls [0:5];
    int          n_checks = 0;
    int          n_pass   = 0;

    fm_wm_adj_reader dut (
        .clk          (clk),
        .reset        (reset),
        .done_comb    (done_comb),
        .fm_wm_adj_out(rd_data),
        .read_row_adj (read_row_adj),
        .class_valid  (class_valid),
        .class_ready  (class_ready),
        .class_node   (class_node),
        .class_idx    (class_idx),
        .done_read    (done_read)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Result memory model: data for the driven address is visible in the following cycle.
    always_comb begin
        for (int c = 0; c < 3; c++)
            rd_data[c] = (read_row_adj < 3'd6) ? mem[read_row_adj][c] : 16'h0000;
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic load_basic();
        for (int n = 0; n < 6; n++) begin
            for (int c = 0; c < 3; c++)
                mem[n][c] = (c == n % 3) ? 16'(100 + n) : 16'(n);
            exp_cls[n] = n % 3;
        end
    endtask

    task automatic set_row(input int n, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] c, input int e);
        mem[n][0] = a;
        mem[n][1] = b;
        mem[n][2] = c;
        exp_cls[n] = e;
    endtask

    task automatic load_ties();
        set_row(0, 16'd7,    16'd7,    16'd3,    0);
        set_row(1, 16'hFFFB, 16'hFFFE, 16'hFFF7, 1);
`ifdef FM_WM_ADJ_SIGNED_ARGMAX_EN
        set_row(2, 16'h8000, 16'h0001, 16'h0000, 1);
        set_row(5, 16'hFFFF, 16'h0001, 16'h0000, 1);
`else
        set_row(2, 16'h8000, 16'h0001, 16'h0000, 0);
        set_row(5, 16'hFFFF, 16'h0001, 16'h0000, 0);
`endif
        set_row(3, 16'd5,    16'd5,    16'd5,    0);
        set_row(4, 16'd1,    16'd2,    16'd2,    1);
    endtask

    // Starts a sweep (caller sits at a negedge) and collects all six results.
    task automatic sweep(input string tag, input int bp_node, input int bp_len, input bit drop_after0);
        int waited;
        done_comb = 1'b1;
        waited = 0;
        for (int n = 0; n < 6; n++) begin
            while (!class_valid && waited < 12) begin
                @(negedge clk);
                waited++;
            end
            check({tag, "_valid"}, int'(class_valid), 1);
            check({tag, "_spacing"}, waited, 3);
            check({tag, "_node"}, int'(class_node), n);
            check({tag, "_idx"}, int'(class_idx), exp_cls[n]);
            if (n == bp_node) begin
                class_ready = 1'b0;
                repeat (bp_len) begin
                    @(negedge clk);
                    check({tag, "_bp_valid"}, int'(class_valid), 1);
                    check({tag, "_bp_node"}, int'(class_node), n);
                    check({tag, "_bp_idx"}, int'(class_idx), exp_cls[n]);
                end
                class_ready = 1'b1;
            end
            @(negedge clk);
            check({tag, "_drop"}, int'(class_valid), 0);
            waited = 1;
            if (drop_after0 && n == 0) done_comb = 1'b0;
        end
        waited = 0;
        while (!done_read && waited < 3) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_done"}, int'(done_read), 1);
        if (done_comb) begin
            @(negedge clk);
            check({tag, "_done_hold"}, int'(done_read), 1);
            done_comb = 1'b0;
        end
        @(negedge clk);
        check({tag, "_done_clear"}, int'(done_read), 0);
    endtask

    task automatic idle_quiet(input string tag, input int cycles);
        int seen_valid;
        int seen_addr;
        seen_valid = 0;
        seen_addr  = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (class_valid) seen_valid++;
            if (read_row_adj != 3'd0) seen_addr++;
        end
        check({tag, "_no_valid"}, seen_valid, 0);
        check({tag, "_addr0"}, seen_addr, 0);
    endtask

    initial begin
        int waited;
        reset       = 1'b0;
        done_comb   = 1'b0;
        class_ready = 1'b1;
        load_basic();
        #1;
        check("rst_row", int'(read_row_adj), 0);
        check("rst_valid", int'(class_valid), 0);
        check("rst_node", int'(class_node), 0);
        check("rst_idx", int'(class_idx), 0);
        check("rst_done", int'(done_read), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        idle_quiet("post_rst", 20);

        sweep("basic", -1, 0, 1'b0);
        idle_quiet("after_basic", 4);

        sweep("bp", 2, 5, 1'b0);
        idle_quiet("after_bp", 4);

        load_ties();
        sweep("ties", -1, 0, 1'b1);
        idle_quiet("after_ties", 6);

        // Reset during node 3 OUT, then restart from node 0.
        load_basic();
        done_comb = 1'b1;
        waited = 0;
        while (!(class_valid && class_node == 3'd3) && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        check("mid_reach_node3", int'(class_valid && class_node == 3'd3), 1);
        #2;
        reset = 1'b0;
        #1;
        check("mid_async_valid", int'(class_valid), 0);
        check("mid_async_node", int'(class_node), 0);
        check("mid_async_row", int'(read_row_adj), 0);
        done_comb = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        idle_quiet("mid_wait", 6);
        sweep("restart", -1, 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
